// File: rtl/nn_pkg.sv
// Shared definitions for the node requantization stage: FSM states, activation
// selects and the reference round/shift/saturate helper.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int unsigned ACT_NONE = 0;
  localparam int unsigned ACT_RELU = 1;

  // Round half up by 'shift' fraction bits, then clip to a signed 'width'-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int unsigned shift,
                                                   input int unsigned width);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t = acc;
    if (shift != 0) t = (t + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (t > hi) t = hi;
    else if (t < lo) t = lo;
    return t;
  endfunction

endpackage

// File: rtl/node_requant_lane.sv
// requant_lane: two-stage round/shift then saturate/activate pipe for one lane.
// Optional clip flag exported when NODE_REQUANT_SAT_CNT_EN is defined.
module requant_lane
  import nn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 26,
  parameter int unsigned ACC_FRAC  = 21,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRACTION  = 14,
  parameter int unsigned ACT       = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid,
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic                        res_valid,
  output logic signed [WIDTH-1:0]     res_c
`ifdef NODE_REQUANT_SAT_CNT_EN
  , output logic                      sat_c
`endif
);

  localparam int unsigned TW    = ACC_WIDTH + 1;
  localparam int unsigned SHIFT = ACC_FRAC - FRACTION;
  localparam logic signed [TW-1:0] RND =
    (SHIFT == 0) ? '0 : TW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1);

  if (ACC_FRAC < FRACTION) begin : g_bad_frac
    $error("requant_lane: ACC_FRAC must be >= FRACTION");
  end

  logic signed [TW-1:0]    t1;
  logic signed [WIDTH-1:0] clipped;

  // Stage 1: add the half-LSB term in the widened domain, then drop fraction bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      t1        <= '0;
    end else begin
      res_valid <= valid;
      if (valid) t1 <= (TW'(acc) + RND) >>> SHIFT;
    end
  end

  // Stage 2: saturate to the output range, then apply the activation.
  always_comb begin
    clipped = WIDTH'(sat_round(64'(t1), 0, WIDTH));
    res_c   = clipped;
    if (ACT == ACT_RELU && clipped[WIDTH-1]) res_c = '0;
  end

`ifdef NODE_REQUANT_SAT_CNT_EN
  assign sat_c = (TW'(clipped) != t1);
`endif

endmodule

// File: rtl/node_requant.sv
// node_requant: captures NODE_NUM accumulators, requantizes one lane per cycle
// and publishes the packed vector at once. NODE_REQUANT_SAT_CNT_EN adds sat_cnt.
module node_requant
  import nn_pkg::*;
#(
  parameter int unsigned NODE_NUM  = 2,
  parameter int unsigned ACC_WIDTH = 26,
  parameter int unsigned ACC_FRAC  = 21,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRACTION  = 14,
  parameter int unsigned ACT       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_ready,
  input  logic [ACC_WIDTH*NODE_NUM-1:0] acc_in,
  output logic [WIDTH*NODE_NUM-1:0]     out,
  output logic                          out_ready,
  output logic                          busy,
  output logic                          drop_err
`ifdef NODE_REQUANT_SAT_CNT_EN
  , output logic [15:0]                 sat_cnt
`endif
);

  localparam int unsigned CW = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;

  state_t state;
  state_t state_next;
  logic   capture;
  logic   issue;
  logic   finish;

  logic [CW-1:0]              cnt;
  logic [CW-1:0]              idx1;
  logic signed [ACC_WIDTH-1:0] hold [NODE_NUM];
  logic signed [WIDTH-1:0]     shadow [NODE_NUM];
  logic signed [WIDTH-1:0]     shadow_next [NODE_NUM];
  logic [WIDTH*NODE_NUM-1:0]   out_next;

  logic                    lane_valid;
  logic signed [WIDTH-1:0] lane_res;
`ifdef NODE_REQUANT_SAT_CNT_EN
  logic                    lane_sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (cnt == CW'(NODE_NUM - 1)) state_next = DRAIN;
      end
      DRAIN: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  requant_lane #(
    .ACC_WIDTH(ACC_WIDTH),
    .ACC_FRAC (ACC_FRAC),
    .WIDTH    (WIDTH),
    .FRACTION (FRACTION),
    .ACT      (ACT)
  ) u_lane (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (issue),
    .acc      (hold[cnt]),
    .res_valid(lane_valid),
    .res_c    (lane_res)
`ifdef NODE_REQUANT_SAT_CNT_EN
    , .sat_c  (lane_sat)
`endif
  );

  // The final lane lands in the same edge that publishes the vector, so merge it here.
  always_comb begin
    out_next = '0;
    for (int k = 0; k < NODE_NUM; k++) shadow_next[k] = shadow[k];
    if (lane_valid) shadow_next[idx1] = lane_res;
    for (int k = 0; k < NODE_NUM; k++) out_next[k*WIDTH +: WIDTH] = shadow_next[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx1      <= '0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
      out       <= '0;
      out_ready <= 1'b0;
      for (int k = 0; k < NODE_NUM; k++) begin
        hold[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      out_ready <= finish;
      if (in_ready && busy) drop_err <= 1'b1;
      if (capture) begin
        busy <= 1'b1;
        cnt  <= '0;
        for (int k = 0; k < NODE_NUM; k++) hold[k] <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
      end
      if (issue) begin
        idx1 <= cnt;
        cnt  <= CW'(cnt + 1'b1);
      end
      for (int k = 0; k < NODE_NUM; k++) shadow[k] <= shadow_next[k];
      if (finish) begin
        out  <= out_next;
        busy <= 1'b0;
      end
    end
  end

`ifdef NODE_REQUANT_SAT_CNT_EN
  // Clip events counted at stage 2, holding at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n) sat_cnt <= '0;
    else if (lane_valid && lane_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_node_requant.sv
// Scoreboard bench for node_requant: ReLU and identity instances share stimulus,
// expected vectors come from a plain-arithmetic model of the requant rules.
module tb_node_requant;

  localparam int unsigned NN = 2;
  localparam int unsigned AW = 26;
  localparam int unsigned OW = 16;

  logic             clk;
  logic             rst_n;
  logic             in_ready;
  logic [AW*NN-1:0] acc_in;
  logic [OW*NN-1:0] out_v  [2];
  logic             rdy_v  [2];
  logic             busy_v [2];
  logic             drop_v [2];
`ifdef NODE_REQUANT_SAT_CNT_EN
  logic [15:0]      satc_v [2];
`endif

  node_requant #(.NODE_NUM(NN), .ACT(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .acc_in(acc_in),
    .out(out_v[0]), .out_ready(rdy_v[0]), .busy(busy_v[0]), .drop_err(drop_v[0])
`ifdef NODE_REQUANT_SAT_CNT_EN
    , .sat_cnt(satc_v[0])
`endif
  );

  node_requant #(.NODE_NUM(NN), .ACT(0)) dut_id (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .acc_in(acc_in),
    .out(out_v[1]), .out_ready(rdy_v[1]), .busy(busy_v[1]), .drop_err(drop_v[1])
`ifdef NODE_REQUANT_SAT_CNT_EN
    , .sat_cnt(satc_v[1])
`endif
  );

  typedef struct {
    logic [OW*NN-1:0] v;
    int               due;
  } exp_t;

  exp_t             q [2][$];
  logic [OW*NN-1:0] exp_out [2];
  int               last_acc;
  logic             drop_exp;
  int               edges;
  int               checks;
  int               failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  // Requantize one lane: floor((a + 64) / 128), clamp to int16, optional ReLU.
  function automatic logic [OW-1:0] model_lane(input logic [AW-1:0] a, input int act);
    longint n, qv;
    n  = longint'($signed(a)) + 64;
    qv = n / 128;
    if ((n % 128 != 0) && (n < 0)) qv = qv - 1;
    if (qv > 32767) qv = 32767;
    if (qv < -32768) qv = -32768;
    if (act == 1 && qv < 0) qv = 0;
    return OW'(qv);
  endfunction

  task automatic do_cyc(input logic s, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic rl);
    int   e;
    exp_t x;
    @(negedge clk);
    #1;
    rst_n    = !rl;
    in_ready = s;
    acc_in   = {a1, a0};
    e        = edges + 1;
    if (rl) begin
      for (int i = 0; i < 2; i++) begin
        q[i].delete();
        exp_out[i] = '0;
      end
      last_acc = -100;
      drop_exp = 1'b0;
    end else if (s) begin
      if (e > last_acc + 3) begin
        last_acc = e;
        for (int i = 0; i < 2; i++) begin
          x.v   = {model_lane(a1, 1 - i), model_lane(a0, 1 - i)};
          x.due = e + 3;
          q[i].push_back(x);
        end
      end else begin
        drop_exp = 1'b1;
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_acc();
    logic [AW-1:0] r;
    case ($urandom_range(0, 5))
      0: r = AW'($urandom);
      1: r = AW'($urandom_range(0, 400)) - AW'(200);
      2: r = 26'h1FFFFFF;
      3: r = 26'h2000000;
      4: r = 26'h3FFFFBF;
      default: r = AW'($urandom_range(0, 32'h7FFFFF)) - AW'(32'h400000);
    endcase
    return r;
  endfunction

  // Monitor: every observed edge is checked against the scoreboard and model state.
  always @(negedge clk) begin
    exp_t x;
    logic bexp;
    if (edges > 0) begin
      bexp = (edges >= last_acc) && (edges < last_acc + 3);
      for (int i = 0; i < 2; i++) begin
        if (rdy_v[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            failures++;
            $display("FAIL unexpected_out_ready dut%0d edge=%0d", i, edges);
          end else begin
            x = q[i].pop_front();
            exp_out[i] = x.v;
            if (x.due != edges) begin
              failures++;
              $display("FAIL latency dut%0d got_edge=%0d want_edge=%0d", i, edges, x.due);
            end
          end
        end else if (q[i].size() != 0 && q[i][0].due <= edges) begin
          checks++;
          failures++;
          $display("FAIL missing_out_ready dut%0d edge=%0d want_edge=%0d", i, edges, q[i][0].due);
          x = q[i].pop_front();
          exp_out[i] = x.v;
        end
        checks++;
        if (out_v[i] !== exp_out[i]) begin
          failures++;
          $display("FAIL out dut%0d edge=%0d got=%h want=%h", i, edges, out_v[i], exp_out[i]);
        end
        checks++;
        if (busy_v[i] !== bexp) begin
          failures++;
          $display("FAIL busy dut%0d edge=%0d got=%b want=%b", i, edges, busy_v[i], bexp);
        end
        checks++;
        if (drop_v[i] !== drop_exp) begin
          failures++;
          $display("FAIL drop_err dut%0d edge=%0d got=%b want=%b", i, edges, drop_v[i], drop_exp);
        end
      end
    end
  end

  initial begin
    edges    = 0;
    checks   = 0;
    failures = 0;
    last_acc = -100;
    drop_exp = 1'b0;
    exp_out[0] = '0;
    exp_out[1] = '0;
    rst_n    = 1'b0;
    in_ready = 1'b0;
    acc_in   = '0;

    do_cyc(1'b0, '0, '0, 1'b1);
    do_cyc(1'b1, 26'h0200000, 26'h0000040, 1'b1);
    do_cyc(1'b0, '0, '0, 1'b0);

    // Unit value and half-LSB rounding.
    do_cyc(1'b1, 26'h0200000, 26'h0000040, 1'b0);
    repeat (4) do_cyc(1'b0, '0, '0, 1'b0);
    // Negative one and positive overflow.
    do_cyc(1'b1, 26'h3E00000, 26'h1FFFFFF, 1'b0);
    repeat (4) do_cyc(1'b0, '0, '0, 1'b0);
    // Most negative accumulator and the rounding boundary just above it.
    do_cyc(1'b1, 26'h2000000, 26'h3FFFFC0, 1'b0);
    repeat (4) do_cyc(1'b0, '0, '0, 1'b0);
    do_cyc(1'b1, 26'h3FFFFBF, 26'h0000040, 1'b0);
    repeat (4) do_cyc(1'b0, '0, '0, 1'b0);

    // Drop while busy, then back-to-back acceptance in the out_ready cycle.
    do_cyc(1'b1, 26'h0100000, 26'h3F00000, 1'b0);
    do_cyc(1'b1, 26'h1FFFFFF, 26'h1FFFFFF, 1'b0);
    do_cyc(1'b0, '0, '0, 1'b0);
    do_cyc(1'b0, '0, '0, 1'b0);
    do_cyc(1'b1, 26'h0012345, 26'h3FEDCBA, 1'b0);
    repeat (4) do_cyc(1'b0, '0, '0, 1'b0);

    // Reset in the middle of a vector, then a clean vector.
    do_cyc(1'b1, 26'h0300000, 26'h0000080, 1'b0);
    do_cyc(1'b0, '0, '0, 1'b0);
    do_cyc(1'b0, '0, '0, 1'b1);
    repeat (3) do_cyc(1'b0, '0, '0, 1'b0);
    do_cyc(1'b1, 26'h00003F0, 26'h3FFFC10, 1'b0);
    repeat (4) do_cyc(1'b0, '0, '0, 1'b0);

    for (int n = 0; n < 800; n++) begin
      do_cyc($urandom_range(0, 2) == 0, rand_acc(), rand_acc(), $urandom_range(0, 99) < 2);
    end
    repeat (6) do_cyc(1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        failures++;
        $display("FAIL pending_vectors dut%0d got=%0d want=0", i, q[i].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/node_requant.md
Name: node_requant

Overview:
- Stage directly downstream of the per-node MAC array of one layer.
- Captures a layer's NODE_NUM parallel wide accumulator results (Q with ACC_FRAC fraction bits) on a single in_ready strobe.
- Requantizes them one lane per cycle through a 2-stage pipeline: round, shift, saturate, activation.
- Presents a packed vector of WIDTH-bit Q(FRACTION) activations with a one-cycle out_ready, ready to feed the next layer's nodes.

Parameters:
- NODE_NUM, 2, number of node lanes in the layer.
- ACC_WIDTH, 26, signed accumulator width per lane.
- ACC_FRAC, 21, fraction bits of accumulator (weight frac 7 + activation frac 14).
- WIDTH, 16, signed output width per lane.
- FRACTION, 14, fraction bits of output.
- ACT, 1, activation: 0 = identity, 1 = ReLU.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_ready  in  1  one-cycle strobe: acc_in valid.
- acc_in  in  ACC_WIDTH*NODE_NUM  lane k at bits [k*ACC_WIDTH +: ACC_WIDTH], signed.
- out  out  WIDTH*NODE_NUM  packed requantized vector, lane k at [k*WIDTH +: WIDTH].
- out_ready  out  1  one-cycle pulse: out updated.
- busy  out  1  high while a vector is in flight.
- drop_err  out  1  sticky: an in_ready arrived while busy.

Behaviour:
- Clock/reset: single clock clk. rst_n is synchronous, active-low, sampled on posedge clk.
- Reset values: out=0, out_ready=0, busy=0, drop_err=0, FSM=IDLE, lane counter=0, pipeline valid bits=0, shadow vector=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + in_ready: capture acc_in into hold register, busy<=1, cnt<=0, go RUN.
  - RUN: each cycle, stage 1 loads lane cnt from hold; cnt increments. When cnt==NODE_NUM-1 is issued, go DRAIN.
  - DRAIN: stage 2 writes the final lane. The same edge copies the complete shadow into out, pulses out_ready=1, clears busy and returns to IDLE.
- Latency: in_ready sampled at edge E0 gives out_ready high after edge E0+NODE_NUM+1, i.e. NODE_NUM+1 cycles.
  - Stage 1 of lane k registers at E0+1+k.
  - Stage 2 writes shadow lane k at E0+2+k.
- Output stability: out changes only on the out_ready edge; lane values are never visible mid-operation.
- Arithmetic, stage 1: t = acc + 2^(ACC_FRAC-FRACTION-1), then arithmetic shift right by ACC_FRAC-FRACTION. This is round-half-up toward +inf; width is ACC_WIDTH+1 to avoid overflow on the add.
- Arithmetic, stage 2:
  - Saturate t to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If ACT==1 and the value is negative, result = 0.
  - ACC_FRAC==FRACTION means no shift and no rounding term. ACC_FRAC<FRACTION is illegal; an elaboration-time check raises an error.
- Back-to-back: in_ready is accepted in the cycle where out_ready is high, since busy is already 0.
- Drops: in_ready while busy is ignored; data is unchanged and the in-flight vector is unaffected. drop_err<=1 and stays set until rst_n.
- Reset mid-operation: everything returns to reset values next edge, the in-flight vector is discarded and no out_ready is issued.
- in_ready coincident with rst_n=0: reset wins.

Optional Feature:
- Macro: NODE_REQUANT_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt (16 bits).
  - Counts lanes clipped by saturation in stage 2, saturating at 0xFFFF; reset to 0 by rst_n.
  - A lane clipped negative then zeroed by ReLU still counts.
- When undefined: port and logic absent; behaviour is otherwise identical.

Decomposition:
- Shared package nn_pkg:
  - FSM state enum typedef (IDLE, RUN, DRAIN).
  - Activation-select constants ACT_NONE=0, ACT_RELU=1.
  - Function sat_round(acc, shift, width) used by both this block and software-model checkers.
- Natural sub-module requant_lane: purely the 2-stage round/shift/saturate/activate pipe for one lane with valid in/out. node_requant instantiates it once and supplies the FSM, hold/shadow registers and packing.

Test Plan (NODE_NUM=2, defaults unless stated):
- Lanes 0x0200000 (1.0), 0x0000040 (half LSB), in_ready one cycle -> out lane0=0x4000, lane1=0x0001; out_ready pulse exactly 3 cycles after strobe; busy high for those 3 cycles.
- Lanes -0x0200000, 0x1FFFFFF, ACT=1 -> lane0=0x0000, lane1=0x7FFF. Same with ACT=0 -> lane0=0xC000. Lane -0x2000000 with ACT=0 -> 0x8000.
- Rounding: lane -0x40 -> 0x0000; lane -0x41 -> 0xFFFF (-1).
- Strobe again 1 cycle after the first -> drop_err=1, first result unaffected. Strobe in the out_ready cycle -> accepted, second out_ready 3 cycles later.
- rst_n low for 1 cycle during RUN -> no out_ready, out=0, busy=0; next strobe processes normally.
- With NODE_REQUANT_SAT_CNT_EN: vectors {0x1FFFFFF, -0x2000000} then {0,0} -> sat_cnt=2.
